// File: rtl/vga_timing_gen_pkg.sv
// Mode constants for the VGA raster timing generator, plus a helper that
// sums the four segments of a line or frame into its total length.
package vga_timing_pkg;

    localparam int VGA640_H_DISP = 640;
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_V_DISP = 480;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;

    localparam int SVGA800_H_DISP = 800;
    localparam int SVGA800_H_FP   = 40;
    localparam int SVGA800_H_SYNC = 128;
    localparam int SVGA800_H_BP   = 88;
    localparam int SVGA800_V_DISP = 600;
    localparam int SVGA800_V_FP   = 1;
    localparam int SVGA800_V_SYNC = 4;
    localparam int SVGA800_V_BP   = 23;

    function automatic int mode_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Clock divider producing a one-clk pixel_tick every CLK_DIV enabled cycles;
// restart realigns the phase so the next tick lands CLK_DIV cycles later.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic pixel_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (restart) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Gated by reset so the tick reads low for as long as reset is held.
    assign pixel_tick = en && !reset && (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with sync, blanking and
// line/frame markers registered from next-state counts, so all stay aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISP  = VGA640_H_DISP,
    parameter int H_FP    = VGA640_H_FP,
    parameter int H_SYNC  = VGA640_H_SYNC,
    parameter int H_BP    = VGA640_H_BP,
    parameter int V_DISP  = VGA640_V_DISP,
    parameter int V_FP    = VGA640_V_FP,
    parameter int V_SYNC  = VGA640_V_SYNC,
    parameter int V_BP    = VGA640_V_BP,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int CLK_DIV = 4,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          restart,
    output logic          pixel_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          video_on,
    output logic          h_sync,
    output logic          v_sync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = mode_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = mode_total(V_DISP, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS     = CW'(H_DISP);
    localparam logic [CW-1:0] V_VIS     = CW'(V_DISP);
    localparam logic [CW-1:0] H_SYNC_LO = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0] H_SYNC_HI = CW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SYNC_LO = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0] V_SYNC_HI = CW'(V_DISP + V_FP + V_SYNC - 1);

    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .restart   (restart),
        .pixel_tick(tick)
    );

    assign pixel_tick = tick;
    assign h_wrap     = tick && (pixel_x == H_LAST);
    assign v_wrap     = h_wrap && (pixel_y == V_LAST);

    always_comb begin
        x_nxt = pixel_x;
        y_nxt = pixel_y;
        if (restart) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (tick) begin
            x_nxt = h_wrap ? '0 : pixel_x + 1'b1;
            if (h_wrap) begin
                y_nxt = v_wrap ? '0 : pixel_y + 1'b1;
            end
        end
    end

    // Decoding from x_nxt/y_nxt keeps sync and blanking on the same edge as the position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b1;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (restart || en) begin
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            h_sync      <= ((x_nxt >= H_SYNC_LO) && (x_nxt <= H_SYNC_HI)) ? H_POL : ~H_POL;
            v_sync      <= ((y_nxt >= V_SYNC_LO) && (y_nxt <= V_SYNC_HI)) ? V_POL : ~V_POL;
            line_start  <= !restart && h_wrap;
            frame_start <= !restart && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a linear-pixel-index reference model pushes expected
// outputs per clk; a negedge monitor pops and compares against two DUTs.
module tb_vga_timing_gen;

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb, div;
        bit hp, vp;
    } mode_t;

    typedef struct {
        int phase;
        int pos;
        bit ls;
        bit fs;
    } mst_t;

    typedef struct packed {
        logic        tick;
        logic [15:0] x;
        logic [15:0] y;
        logic        vid;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 640x480 mode, CLK_DIV=4, active-low syncs
    logic        reset_a, en_a, restart_a;
    logic        pixel_tick_a, video_on_a, h_sync_a, v_sync_a, line_start_a, frame_start_a;
    logic [9:0]  pixel_x_a, pixel_y_a;

    // DUT B: 800-wide line, short frame, CLK_DIV=1, active-high syncs
    logic        reset_b, en_b, restart_b;
    logic        pixel_tick_b, video_on_b, h_sync_b, v_sync_b, line_start_b, frame_start_b;
    logic [10:0] pixel_x_b, pixel_y_b;

    vga_timing_gen dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .en         (en_a),
        .restart    (restart_a),
        .pixel_tick (pixel_tick_a),
        .pixel_x    (pixel_x_a),
        .pixel_y    (pixel_y_a),
        .video_on   (video_on_a),
        .h_sync     (h_sync_a),
        .v_sync     (v_sync_a),
        .line_start (line_start_a),
        .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .H_DISP(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_DISP(6),   .V_FP(1),  .V_SYNC(4),   .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(11)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .en         (en_b),
        .restart    (restart_b),
        .pixel_tick (pixel_tick_b),
        .pixel_x    (pixel_x_b),
        .pixel_y    (pixel_y_b),
        .video_on   (video_on_b),
        .h_sync     (h_sync_b),
        .v_sync     (v_sync_b),
        .line_start (line_start_b),
        .frame_start(frame_start_b)
    );

    mode_t ma, mb;
    mst_t  sa, sb;
    exp_t  qa[$];
    exp_t  qb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc_n = 0;

    function automatic mst_t rst_state();
        mst_t s;
        s.phase = 0;
        s.pos   = 0;
        s.ls    = 1'b0;
        s.fs    = 1'b0;
        return s;
    endfunction

    function automatic exp_t decode(input mode_t m, input mst_t s, input bit tick);
        exp_t e;
        int ht, x, y;
        ht    = m.hd + m.hf + m.hs + m.hb;
        x     = s.pos % ht;
        y     = s.pos / ht;
        e.tick = tick;
        e.x    = 16'(x);
        e.y    = 16'(y);
        e.vid  = (x < m.hd) && (y < m.vd);
        e.hs   = (x >= m.hd + m.hf && x < m.hd + m.hf + m.hs) ? m.hp : !m.hp;
        e.vs   = (y >= m.vd + m.vf && y < m.vd + m.vf + m.vs) ? m.vp : !m.vp;
        e.ls   = s.ls;
        e.fs   = s.fs;
        return e;
    endfunction

    function automatic mst_t step(input mode_t m, input mst_t s, input bit en, input bit rs);
        mst_t n;
        int ht, ft;
        n  = s;
        ht = m.hd + m.hf + m.hs + m.hb;
        ft = ht * (m.vd + m.vf + m.vs + m.vb);
        if (rs) begin
            n = rst_state();
        end else if (en) begin
            if (s.phase == m.div - 1) begin
                n.pos = (s.pos + 1) % ft;
                n.ls  = (n.pos % ht) == 0;
                n.fs  = (n.pos == 0);
            end else begin
                n.ls = 1'b0;
                n.fs = 1'b0;
            end
            n.phase = (s.phase + 1) % m.div;
        end
        return n;
    endfunction

    // Issue one clk of stimulus: push what each DUT must show this cycle, advance the model.
    task automatic cyc();
        bit t;
        if (reset_a) sa = rst_state();
        t = !reset_a && en_a && (sa.phase == ma.div - 1);
        qa.push_back(decode(ma, sa, t));
        if (!reset_a) sa = step(ma, sa, en_a, restart_a);

        if (reset_b) sb = rst_state();
        t = !reset_b && en_b && (sb.phase == mb.div - 1);
        qb.push_back(decode(mb, sb, t));
        if (!reset_b) sb = step(mb, sb, en_b, restart_b);

        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic check(input string nm, input exp_t e, input exp_t g);
        total++;
        if (e !== g) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s cyc=%0d got tick=%0b x=%0d y=%0d vid=%0b hs=%0b vs=%0b ls=%0b fs=%0b exp tick=%0b x=%0d y=%0d vid=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                         nm, cyc_n, g.tick, g.x, g.y, g.vid, g.hs, g.vs, g.ls, g.fs,
                         e.tick, e.x, e.y, e.vid, e.hs, e.vs, e.ls, e.fs);
        end
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            g = {pixel_tick_a, 16'(pixel_x_a), 16'(pixel_y_a), video_on_a,
                 h_sync_a, v_sync_a, line_start_a, frame_start_a};
            check("dut_a", e, g);
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            g = {pixel_tick_b, 16'(pixel_x_b), 16'(pixel_y_b), video_on_b,
                 h_sync_b, v_sync_b, line_start_b, frame_start_b};
            check("dut_b", e, g);
        end
    end

    initial begin
        int nf;
        ma = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, div:4, hp:1'b0, vp:1'b0};
        mb = '{hd:800, hf:40, hs:128, hb:88, vd:6, vf:1, vs:4, vb:3, div:1, hp:1'b1, vp:1'b1};
        sa = rst_state();
        sb = rst_state();
        reset_a = 1'b1; en_a = 1'b1; restart_a = 1'b0;
        reset_b = 1'b1; en_b = 1'b1; restart_b = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc();
        reset_a = 1'b0;
        reset_b = 1'b0;

        // A: run to x=100 right after its tick, then freeze for 37 clk
        for (int i = 0; i < 1000 && !(sa.pos == 100 && sa.phase == 0); i++) cyc();
        en_a = 1'b0;
        repeat (37) cyc();
        en_a = 1'b1;

        // A: restart on the tick that would move line 1 past x=700
        for (int i = 0; i < 8000 && !(sa.pos == 800 + 700 && sa.phase == 3); i++) cyc();
        restart_a = 1'b1;
        cyc();
        restart_a = 1'b0;
        repeat (20) cyc();

        // A: randomized enable gaps and occasional restarts
        for (int i = 0; i < 2000; i++) begin
            en_a      = ($urandom_range(0, 9) != 0);
            restart_a = ($urandom_range(0, 499) == 0);
            cyc();
        end
        en_a = 1'b1;
        restart_a = 1'b0;

        // B: run through two frame wraps
        nf = 0;
        for (int i = 0; i < 40000 && nf < 2; i++) begin
            cyc();
            if (sb.fs) nf++;
        end

        // B: async reset mid-frame
        repeat (5000) cyc();
        reset_b = 1'b1;
        repeat (2) cyc();
        reset_b = 1'b0;
        repeat (300) cyc();

        // Both: randomized enable/restart traffic
        for (int i = 0; i < 3000; i++) begin
            en_a      = ($urandom_range(0, 7) != 0);
            restart_a = ($urandom_range(0, 299) == 0);
            en_b      = ($urandom_range(0, 5) != 0);
            restart_b = ($urandom_range(0, 299) == 0);
            cyc();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the video path of the display project. It divides the board clock into a pixel clock-enable and counts pixels and lines. It produces registered, mutually aligned sync, blanking and position outputs, plus line and frame markers, for the pixel/colour generation logic downstream. Resolution, porch widths, sync polarity and clock ratio are set by parameters, so one block covers 640x480 and other modes.

## Interface
- H_DISP, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_DISP, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- H_POL, 0: h_sync active level (0 = active-low)
- V_POL, 0: v_sync active level
- CLK_DIV, 4: clk cycles per pixel, >= 1
- CW, 10: counter width; 2^CW must be >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- en  in  1  run enable; low freezes divider and counters
- restart  in  1  synchronous; forces position (0,0) and divider phase 0 on next clk
- pixel_tick  out  1  one-clk pulse per pixel period
- pixel_x  out  CW  current column, 0..H_TOTAL-1
- pixel_y  out  CW  current line, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x < H_DISP and pixel_y < V_DISP
- h_sync  out  1  horizontal sync, polarity H_POL
- v_sync  out  1  vertical sync, polarity V_POL
- line_start  out  1  one-clk pulse when pixel_x wraps to 0
- frame_start  out  1  one-clk pulse when position wraps to (0,0)

## Operation
- Derived constants: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP and V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP. Per-line order is display, front porch, sync, back porch. Vertical follows the same order.
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. pixel_tick is high on the clk cycle where div_cnt = CLK_DIV-1. With CLK_DIV=1, pixel_tick = en.
- On a tick, the horizontal counter increments. At H_TOTAL-1 it wraps to 0, and the vertical counter increments. The vertical counter wraps from V_TOTAL-1 to 0.
- h_sync is active for pixel_x in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1]. v_sync is active for pixel_y in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1]. Both are decoded from their own counter only.
- All outputs except pixel_tick are registered. Sync, video_on and marker outputs are decoded from next-state counts, so they always describe the pixel_x/pixel_y currently presented. There is no skew between position and sync/blank.
- en=0: pixel_tick=0, all counters and registered outputs hold their values. Resuming continues from the held divider phase.
- restart=1 has priority over en and tick. On the next edge: div_cnt=0, position (0,0), line_start=0, frame_start=0, and the other outputs are decoded for (0,0).
- Reset mid-frame: all state goes immediately to its reset values. There is no partial-frame completion.

## Timing
- Reset values: div_cnt=0, pixel_x=0, pixel_y=0, video_on=1, h_sync=~H_POL, v_sync=~V_POL, line_start=0, frame_start=0, pixel_tick=0.
- First pixel_tick occurs CLK_DIV clk cycles after reset deasserts (cycle CLK_DIV-1 counting from 0) with en=1.
- Position and all registered outputs update on the clk edge that samples pixel_tick=1, giving a latency of 1 clk from the tick.
- line_start and frame_start are high for exactly one clk, after the edge where the wrap happens. On the frame wrap, both pulse together.
- Line period = H_TOTAL*CLK_DIV clk. Frame period = H_TOTAL*V_TOTAL*CLK_DIV clk.
- Arithmetic is unsigned, CW bits. Counters compare equal to TOTAL-1 and never exceed it.

## Structure
- Package vga_timing_pkg holds the mode constants for 640x480@60 (values above). Optional further mode sets live there, along with a function computing H_TOTAL/V_TOTAL.
- Sub-module pixel_tick_div (parametrised divider with en and restart) produces pixel_tick. The H/V counters and decode stay in the top level.

## Test plan
- Defaults, en=1, reset released at t0 -> first pixel_tick at clk 3. pixel_x=1 at clk 4. Tick period is 4 clk.
- Run one line -> h_sync low for pixel_x 656..751 (96 px). video_on low from pixel_x 640. line_start pulses as pixel_x goes 799->0. pixel_y becomes 1.
- Run a full frame -> v_sync low for pixel_y 490..491. video_on low for pixel_y >= 480. frame_start pulses once after 800*525*4 = 1,680,000 clk. Position returns to (0,0).
- Drop en for 37 clk mid-line at pixel_x=100 -> no ticks, all outputs frozen. After re-enable, ticks resume with the same phase, and pixel_x=101 on the next tick.
- Assert restart at pixel (700,300) together with a tick -> next clk: (0,0), video_on=1, syncs inactive, no line_start/frame_start. Next tick after 4 clk.
- Override H_POL=1, V_POL=1, CLK_DIV=1, 800x600 constants (H 800/40/128/88, V 600/1/4/23) -> active-high syncs at x 840..967 and y 601..604. A tick every clk. Frame = 1056*628 clk. Async reset mid-frame returns all outputs to reset values at once.
